mem_access_stage: RTL and testbench

- MEM stage of the pipelined LEGv8 core, directly downstream of execute.
- Holds the EX/MEM pipeline register, which captures execute's branch target, ALU result, store data and zero flag plus decode control.
- Drives a handshaked data memory. Stalls the pipeline until the memory acknowledges or times out.
- Resolves conditional branches (PCSrc) and presents load data and control to writeback.

---
 rtl/mem_access_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// LEGv8 MEM stage: EX/MEM pipeline register, handshaked data-memory access with
// timeout, branch resolution and writeback pass-through.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] PCBranch_E,
  input  logic [63:0] aluResult_E,
  input  logic [63:0] writeData_E,
  input  logic        zero_E,
  input  logic        valid_E,
  input  logic        Branch_E,
  input  logic        MemRead_E,
  input  logic        MemWrite_E,
  input  logic        RegWrite_E,
  input  logic        MemtoReg_E,
  input  logic [4:0]  rd_E,
  input  logic        flush_E,
  output logic        dm_req,
  output logic        dm_we,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [63:0] dm_rdata,
  output logic        stall_M,
  output logic        PCSrc_M,
  output logic [63:0] PCBranch_M,
  output logic [63:0] aluResult_M,
  output logic [63:0] readData_M,
  output logic [4:0]  rd_M,
  output logic        RegWrite_M,
  output logic        MemtoReg_M,
  output logic        valid_M,
  output logic        align_err,
  output logic        bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     pc_branch_q, pc_branch_d;
  logic [63:0]     alu_q, alu_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [63:0]     read_data_q, read_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            zero_q, zero_d;
  logic            valid_q, valid_d;
  logic            branch_q, branch_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            align_err_q, align_err_d;
  logic            bus_err_q, bus_err_d;
  // Suppresses the register write of an instruction whose access timed out.
  logic            wb_kill_q, wb_kill_d;

  logic mem_op, misaligned, is_load, req, timeout;

  always_comb begin
    mem_op     = valid_q & (mem_read_q | mem_write_q);
    misaligned = mem_op & (alu_q[2:0] != 3'b000);
    is_load    = mem_op & ~mem_write_q;
    req        = mem_op & ~misaligned & ((state_q == StIdle) | (state_q == StWait));
    timeout    = (state_q == StWait) & ~dm_ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    read_data_d  = read_data_q;
    align_err_d  = align_err_q | misaligned;
    bus_err_d    = bus_err_q;
    wb_kill_d    = wb_kill_q;
    pc_branch_d  = pc_branch_q;
    alu_d        = alu_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    zero_d       = zero_q;
    valid_d      = valid_q;
    branch_d     = branch_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;

    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (dm_ack) begin
            state_d = StDone;
            if (is_load) read_data_d = dm_rdata;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(1);
          end
        end
      end
      StWait: begin
        if (dm_ack) begin
          state_d = StDone;
          if (is_load) read_data_d = dm_rdata;
        end else if (timeout) begin
          state_d   = StDone;
          bus_err_d = 1'b1;
          wb_kill_d = 1'b1;
          if (is_load) read_data_d = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    if (!req) begin
      pc_branch_d  = PCBranch_E;
      alu_d        = aluResult_E;
      wdata_d      = writeData_E;
      rd_d         = rd_E;
      zero_d       = zero_E;
      valid_d      = valid_E & ~flush_E;
      branch_d     = Branch_E & ~flush_E;
      mem_read_d   = MemRead_E & ~flush_E;
      mem_write_d  = MemWrite_E & ~flush_E;
      reg_write_d  = RegWrite_E & ~flush_E;
      mem_to_reg_d = MemtoReg_E & ~flush_E;
      wb_kill_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      read_data_q  <= '0;
      align_err_q  <= 1'b0;
      bus_err_q    <= 1'b0;
      wb_kill_q    <= 1'b0;
      pc_branch_q  <= '0;
      alu_q        <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      zero_q       <= 1'b0;
      valid_q      <= 1'b0;
      branch_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_data_q  <= read_data_d;
      align_err_q  <= align_err_d;
      bus_err_q    <= bus_err_d;
      wb_kill_q    <= wb_kill_d;
      pc_branch_q  <= pc_branch_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      zero_q       <= zero_d;
      valid_q      <= valid_d;
      branch_q     <= branch_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign dm_req      = req;
  assign stall_M     = req;
  assign dm_we       = mem_write_q;
  assign dm_addr     = alu_q;
  assign dm_wdata    = wdata_q;
  assign PCSrc_M     = valid_q & branch_q & zero_q;
  assign PCBranch_M  = pc_branch_q;
  assign aluResult_M = alu_q;
  assign readData_M  = read_data_q;
  assign rd_M        = rd_q;
  assign RegWrite_M  = reg_write_q & ~misaligned & ~wb_kill_q;
  assign MemtoReg_M  = mem_to_reg_q;
  assign valid_M     = valid_q;
  assign align_err   = align_err_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, ack delay, timeout,
// misalignment, branches, flush and reset during an outstanding access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] PCBranch_E, aluResult_E, writeData_E;
  logic        zero_E, valid_E, Branch_E, MemRead_E, MemWrite_E, RegWrite_E, MemtoReg_E;
  logic [4:0]  rd_E;
  logic        flush_E;
  logic        dm_req, dm_we, dm_ack;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        stall_M, PCSrc_M;
  logic [63:0] PCBranch_M, aluResult_M, readData_M;
  logic [4:0]  rd_M;
  logic        RegWrite_M, MemtoReg_M, valid_M, align_err, bus_err;

  int errors = 0;
  int checks = 0;
  int stalls;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .PCBranch_E(PCBranch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
    .zero_E(zero_E), .valid_E(valid_E), .Branch_E(Branch_E), .MemRead_E(MemRead_E),
    .MemWrite_E(MemWrite_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
    .rd_E(rd_E), .flush_E(flush_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
    .aluResult_M(aluResult_M), .readData_M(readData_M), .rd_M(rd_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .valid_M(valid_M),
    .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic br, input logic mr, input logic mw,
                       input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] pcb,
                       input logic z, input logic fl);
    valid_E = v; Branch_E = br; MemRead_E = mr; MemWrite_E = mw; RegWrite_E = rw;
    MemtoReg_E = m2r; rd_E = rd; aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
    zero_E = z; flush_E = fl;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0, 0);
  endtask

  // Drive one instruction into E, let it load into MEM, then return in its first MEM cycle.
  task automatic issue(input logic br, input logic mr, input logic mw, input logic rw,
                       input logic m2r, input logic [4:0] rd, input logic [63:0] alu,
                       input logic [63:0] wd, input logic [63:0] pcb, input logic z,
                       input logic fl);
    @(posedge clk); #1;
    drive(1, br, mr, mw, rw, m2r, rd, alu, wd, pcb, z, fl);
    @(posedge clk); #1;
  endtask

  // Count stall cycles; ack is raised in stall cycle ack_at (-1 = never). Returns at the
  // negedge of the first non-stalled cycle.
  task automatic run_mem(input int ack_at, input logic [63:0] rdata, input logic exp_we,
                         input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                         output int n_stall);
    bit done = 0;
    n_stall = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (dm_req) begin
        check("req_we", dm_we, exp_we);
        check("req_addr", dm_addr, exp_addr);
        check("req_wdata", dm_wdata, exp_wdata);
      end
      if (!stall_M) begin
        done = 1;
        break;
      end
      n_stall++;
      dm_ack = (n == ack_at);
      dm_rdata = rdata;
      @(posedge clk); #1;
      dm_ack = 1'b0;
    end
    check("stall_bound", done, 1);
  endtask

  initial begin
    reset = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    bubble();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_req", dm_req, 0);
    check("rst_stall", stall_M, 0);
    check("rst_pcsrc", PCSrc_M, 0);
    check("rst_valid", valid_M, 0);
    check("rst_rdata", readData_M, 0);
    check("rst_errs", {align_err, bus_err}, 0);

    // Load with same-cycle ack.
    issue(0, 1, 0, 1, 1, 5'd5, 64'h40, 64'h0, 64'h0, 0, 0);
    bubble();
    run_mem(0, 64'hDEADBEEF, 0, 64'h40, 64'h0, stalls);
    check("ld_stalls", stalls, 1);
    check("ld_rdata", readData_M, 64'hDEADBEEF);
    check("ld_regwrite", RegWrite_M, 1);
    check("ld_rd", rd_M, 5);
    check("ld_memtoreg", MemtoReg_M, 1);

    // Store, ack in the fourth stall cycle; a non-memory op waits in E meanwhile.
    issue(0, 0, 1, 0, 0, 5'd0, 64'h80, 64'h1234, 64'h0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 5'd7, 64'h77, 64'h0, 64'h0, 0, 0);
    run_mem(3, 64'hBAD, 1, 64'h80, 64'h1234, stalls);
    check("st_stalls", stalls, 4);
    check("st_rdata_hold", readData_M, 64'hDEADBEEF);
    @(posedge clk); #1;
    bubble();
    @(negedge clk);
    check("st_next_rd", rd_M, 7);
    check("st_next_alu", aluResult_M, 64'h77);
    check("st_next_stall", stall_M, 0);

    // Reset while a load sits in WAIT; a late ack must be ignored.
    issue(0, 1, 0, 1, 1, 5'd3, 64'h48, 64'h0, 64'h0, 0, 0);
    bubble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pre_req", dm_req, 1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req", dm_req, 0);
    check("rst_mid_stall", stall_M, 0);
    check("rst_mid_valid", valid_M, 0);
    check("rst_mid_rdata", readData_M, 0);
    dm_ack = 1'b1; dm_rdata = 64'hCAFE;
    @(posedge clk); #1 dm_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rdata", readData_M, 0);
    check("late_ack_stall", stall_M, 0);

    // Load with one cycle of ack delay.
    issue(0, 1, 0, 1, 1, 5'd9, 64'h10, 64'h0, 64'h0, 0, 0);
    bubble();
    run_mem(1, 64'h1111, 0, 64'h10, 64'h0, stalls);
    check("ld2_stalls", stalls, 2);
    check("ld2_rdata", readData_M, 64'h1111);

    // Load that never gets an ack.
    issue(0, 1, 0, 1, 1, 5'd4, 64'h20, 64'h0, 64'h0, 0, 0);
    bubble();
    run_mem(-1, 64'h0, 0, 64'h20, 64'h0, stalls);
    check("to_stalls", stalls, 16);
    check("to_bus_err", bus_err, 1);
    check("to_rdata", readData_M, 0);
    check("to_regwrite", RegWrite_M, 0);
    check("to_valid", valid_M, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_sticky", bus_err, 1);

    // Misaligned load.
    issue(0, 1, 0, 1, 1, 5'd2, 64'h43, 64'h0, 64'h0, 0, 0);
    bubble();
    run_mem(-1, 64'h0, 0, 64'h43, 64'h0, stalls);
    check("mis_stalls", stalls, 0);
    check("mis_req", dm_req, 0);
    check("mis_regwrite", RegWrite_M, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_align_err", align_err, 1);
    check("mis_req_after", dm_req, 0);

    // Taken branch: PCSrc for exactly one cycle.
    issue(1, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h100, 1, 0);
    bubble();
    @(negedge clk);
    check("br_pcsrc", PCSrc_M, 1);
    check("br_target", PCBranch_M, 64'h100);
    check("br_stall", stall_M, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("br_pcsrc_off", PCSrc_M, 0);

    // Not taken, then flushed branch.
    issue(1, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h200, 0, 0);
    bubble();
    @(negedge clk);
    check("bnt_pcsrc", PCSrc_M, 0);
    check("bnt_target", PCBranch_M, 64'h200);
    issue(1, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h100, 1, 1);
    bubble();
    @(negedge clk);
    check("bfl_pcsrc", PCSrc_M, 0);
    check("bfl_valid", valid_M, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
